// File: rtl/apb_sram_arb.sv
// Two-port round-robin arbiter driving an APB master sequencer.
// Runs SETUP/ACCESS with pready wait states and an optional wait timeout.
module apb_sram_arb #(
    parameter int AW      = 12,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic          err0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic          err1,
    output logic [DW-1:0] rdata1,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    input  logic          pready,
    input  logic [DW-1:0] prdata
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t        state, state_n;
    logic [7:0]    wcnt, wcnt_n;
    logic          last_grant;
    logic          cur;
    logic          gnt1;
    logic          go;
    logic          fin;
    logic          tmo;
    logic [AW-1:0] sel_addr;

    // On a tie the port that did not win last time gets the bus
    assign gnt1     = req1 & (~req0 | ~last_grant);
    assign sel_addr = gnt1 ? addr1 : addr0;

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        go      = 1'b0;
        fin     = 1'b0;
        tmo     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 | req1) begin
                    go      = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: state_n = ACCESS;
            ACCESS: begin
                if (pready) begin
                    fin     = 1'b1;
                    state_n = DONE;
                end else if (TO != 8'd0 && wcnt + 8'd1 == TO) begin
                    tmo     = 1'b1;
                    state_n = DONE;
                end else begin
                    wcnt_n = wcnt + 8'd1;
                end
            end
            DONE: begin
                wcnt_n  = 8'd0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state      <= IDLE;
            wcnt       <= 8'd0;
            last_grant <= 1'b1;
            cur        <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state   <= state_n;
            wcnt    <= wcnt_n;
            psel    <= (state_n == SETUP) | (state_n == ACCESS);
            penable <= (state_n == ACCESS);
            ack0    <= (fin | tmo) & ~cur;
            ack1    <= (fin | tmo) & cur;
            err0    <= tmo & ~cur;
            err1    <= tmo & cur;
            if (go) begin
                cur        <= gnt1;
                last_grant <= gnt1;
                pwrite     <= gnt1 ? we1 : we0;
                paddr      <= {sel_addr[AW-1:2], 2'b00};
                pwdata     <= gnt1 ? wdata1 : wdata0;
            end
            if (fin & ~pwrite) begin
                if (cur) rdata1 <= prdata;
                else     rdata0 <= prdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_sram_arb.sv
// Randomized bench for apb_sram_arb with an SRAM responder and a
// transaction-level model of arbitration, latency and memory contents.
module tb_apb_sram_arb;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int TMO = 4;

    typedef struct {
        bit          we;
        logic [11:0] a;
        logic [31:0] d;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, err0, ack1, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          psel, penable, pwrite, pready;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;

    apb_sram_arb #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata)
    );

    always #5 clk = ~clk;

    // SRAM responder: ready after ws_cfg stalled ACCESS cycles
    logic [31:0] mem [1024];
    int          acc_cnt = 0;
    int          ws_cfg = 0;

    assign prdata = mem[paddr[11:2]];
    assign pready = psel && penable && (acc_cnt >= ws_cfg);

    always @(posedge clk) begin
        if (psel && penable && pready && pwrite)
            mem[paddr[11:2]] <= pwdata;
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] ref_mem [int];
    int          written [$];
    logic [31:0] exp_rd [2];
    int          model_last = 1;
    cmd_t        q0 [$];
    cmd_t        q1 [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input cmd_t c, input bit r);
        if (p == 0) begin
            req0 = r; we0 = c.we; addr0 = c.a; wdata0 = c.d;
        end else begin
            req1 = r; we1 = c.we; addr1 = c.a; wdata1 = c.d;
        end
    endtask

    // Apply a completed transfer to the model and check read data
    task automatic settle(input int p, input cmd_t c, input bit to);
        int idx;
        idx = int'(c.a[11:2]);
        if (!to) begin
            if (c.we) begin
                ref_mem[idx] = c.d;
                written.push_back(idx);
            end else begin
                exp_rd[p] = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
            end
        end
        chk("rdata0", rdata0, exp_rd[0]);
        chk("rdata1", rdata1, exp_rd[1]);
        chk("err", (p == 1) ? err1 : err0, 32'(to));
        model_last = p;
    endtask

    task automatic xfer(input int p, input cmd_t c, input int ws);
        bit to;
        int lat;
        to     = (ws >= TMO);
        ws_cfg = ws;
        lat    = 0;
        drive(p, c, 1'b1);
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            chk("ack_excl", 32'(ack0 & ack1), 0);
            if (k == 1) begin
                chk("setup_psel", psel, 1);
                chk("setup_pen", penable, 0);
            end
            if (k >= 2 && !(ack0 | ack1)) begin
                chk("acc_psel", psel, 1);
                chk("acc_pen", penable, 1);
                chk("paddr", paddr, c.a & ~12'h3);
                chk("pwrite", pwrite, c.we);
            end
            if (ack0 | ack1) begin
                lat = k;
                break;
            end
        end
        chk("ack_seen", 32'(lat != 0), 1);
        chk("ack_port", ack1, 32'(p == 1));
        chk("latency", lat, to ? TMO + 2 : 3 + ws);
        drive(p, c, 1'b0);
        settle(p, c, to);
        if (c.we && !to)
            chk("sram", mem[c.a[11:2]], c.d);
        @(posedge clk); #1;
        chk("ack_pulse", 32'(ack0 | ack1), 0);
        chk("idle_psel", psel, 0);
    endtask

    // Both ports drain their queues concurrently
    task automatic pair();
        int   last_ack;
        int   p;
        int   expw;
        cmd_t c;
        ws_cfg   = 0;
        last_ack = 0;
        if (q0.size() > 0) drive(0, q0[0], 1'b1);
        if (q1.size() > 0) drive(1, q1[0], 1'b1);
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            chk("ack_excl", 32'(ack0 & ack1), 0);
            if (ack0 | ack1) begin
                p = ack1 ? 1 : 0;
                if (q0.size() > 0 && q1.size() > 0) expw = 1 - model_last;
                else                                expw = (q0.size() > 0) ? 0 : 1;
                chk("grant", p, expw);
                if (last_ack != 0) chk("gap", k - last_ack, 4);
                else               chk("first_lat", k, 3);
                last_ack = k;
                c = (p == 1) ? q1.pop_front() : q0.pop_front();
                settle(p, c, 1'b0);
                if (p == 1) begin
                    if (q1.size() > 0) drive(1, q1[0], 1'b1);
                    else               drive(1, c, 1'b0);
                end else begin
                    if (q0.size() > 0) drive(0, q0[0], 1'b1);
                    else               drive(0, c, 1'b0);
                end
                if (q0.size() == 0 && q1.size() == 0) break;
            end
        end
        chk("pair_done", q0.size() + q1.size(), 0);
        @(posedge clk); #1;
    endtask

    function automatic cmd_t mk(input bit we, input logic [11:0] a,
                                input logic [31:0] d);
        cmd_t c;
        c.we = we; c.a = a; c.d = d;
        return c;
    endfunction

    initial begin
        logic [31:0] v;
        int          p;
        int          idx;
        exp_rd[0] = 0;
        exp_rd[1] = 0;
        #23 rstn = 1'b0;
        @(posedge clk); #1;
        chk("rst_psel", psel, 0);
        chk("rst_pen", penable, 0);
        chk("rst_ack", 32'(ack0 | ack1), 0);
        chk("rst_err", 32'(err0 | err1), 0);
        chk("rst_rd0", rdata0, 0);
        chk("rst_rd1", rdata1, 0);

        xfer(0, mk(1, 12'h000, 32'hDEADBEEF), 0);
        xfer(0, mk(0, 12'h000, 32'h0), 0);
        chk("wr_rd0", rdata0, 32'hDEADBEEF);

        xfer(1, mk(1, 12'hFFC, 32'hA5A5A5A5), 0);
        chk("mem1023", mem[1023], 32'hA5A5A5A5);
        xfer(1, mk(0, 12'hFFF, 32'h0), 0);
        chk("wr_rd1", rdata1, 32'hA5A5A5A5);

        q0.push_back(mk(1, 12'h100, $urandom));
        q1.push_back(mk(1, 12'h104, $urandom));
        q0.push_back(mk(0, 12'h104, 0));
        q1.push_back(mk(0, 12'h100, 0));
        pair();

        xfer(0, mk(1, 12'h010, 32'h13579BDF), 0);
        xfer(0, mk(0, 12'h010, 32'h0), 3);
        chk("ws_rd0", rdata0, mem[4]);

        xfer(1, mk(0, 12'h000, 32'h0), 255);
        xfer(1, mk(0, 12'h000, 32'h0), 0);

        for (int i = 0; i < 24; i++) begin
            p = int'($urandom_range(0, 1));
            if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
                xfer(p, mk(1, 12'($urandom), $urandom), int'($urandom_range(0, 2)));
            end else begin
                idx = written[$urandom_range(0, written.size() - 1)];
                v = {20'h0, idx[9:0], 2'($urandom)};
                xfer(p, mk(0, v[11:0], 0),
                     ($urandom_range(0, 7) == 0) ? TMO + 1 : int'($urandom_range(0, 2)));
            end
        end

        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1, 12'($urandom), $urandom));
            q1.push_back(mk(1, 12'($urandom), $urandom));
        end
        pair();

        // Reset in the middle of a stalled write
        xfer(0, mk(1, 12'h020, 32'h11112222), 0);
        ws_cfg = 255;
        drive(0, mk(1, 12'h020, 32'h99998888), 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rstn = 1'b1;
        #1;
        chk("mid_psel", psel, 0);
        chk("mid_pen", penable, 0);
        chk("mid_ack", ack0, 0);
        chk("mid_mem", mem[8], 32'h11112222);
        drive(0, mk(0, 12'h0, 32'h0), 1'b0);
        #2 rstn = 1'b0;
        model_last = 1;
        exp_rd[0]  = 0;
        exp_rd[1]  = 0;
        @(posedge clk); #1;
        chk("post_psel", psel, 0);
        q0.push_back(mk(0, 12'h020, 0));
        q1.push_back(mk(0, 12'hFFC, 0));
        pair();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=%0d exp=%0d", 1, 0);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_sram_arb.md
Name: apb_sram_arb

Overview:
- Two-requester arbiter and APB master sequencer in front of apb_sram; replaces the testbench-only APB master model in integrated designs.
- Each requester issues a simple request/acknowledge access (read or write) on its own port.
- The block arbitrates round-robin and runs the APB SETUP/ACCESS protocol, including pready wait states and a wait-state timeout.
- It returns read data or an error to the winning port.

Parameters:
AW, 12, APB address width (byte address; word index = addr[AW-1:2])
DW, 32, data width
TIMEOUT, 16, maximum ACCESS cycles waiting for pready before abort; 0 disables timeout; 8-bit counter, legal range 0..255

Ports:
clk  input  1  clock, rising edge
rstn  input  1  reset, asynchronous, active-high
req0  input  1  port 0 access request, held until ack0
we0  input  1  port 0 direction: 1 write, 0 read; stable while req0
addr0  input  AW  port 0 byte address; stable while req0
wdata0  input  DW  port 0 write data; stable while req0
ack0  output  1  port 0 completion pulse, one cycle
err0  output  1  port 0 timeout flag, valid with ack0
rdata0  output  DW  port 0 read data, valid with ack0 on read
req1, we1, addr1, wdata1, ack1, err1, rdata1: same for port 1
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  AW  APB address, forced to {addr[AW-1:2],2'b00}
pwdata  output  DW  APB write data
pready  input  1  APB ready from apb_sram
prdata  input  DW  APB read data from apb_sram

Behaviour:
- Reset (rstn=1, async): all outputs 0, FSM=IDLE, wait counter=0, last_grant=1 (port 0 wins the first tie).
  - Reset mid-transfer aborts immediately: psel/penable drop, no ack is issued.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any req is high, pick the winner: the only requester, or on a tie the port != last_grant.
  - Latch the winner's we/addr/wdata into pwrite/paddr/pwdata; update last_grant; go to SETUP.
  - No req: stay in IDLE with psel=0.
- SETUP: psel=1, penable=0; always one cycle, then ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr/pwrite/pwdata held stable.
  - pready=1 at the edge: capture prdata (reads only) into the winner's rdata; go to DONE with err=0.
  - pready=0: increment wait counter.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with pready still 0: go to DONE with err=1 and leave rdata unchanged.
- DONE:
  - psel=0, penable=0; winner's ack=1 for exactly one cycle, err valid; wait counter cleared.
  - Next state is always IDLE. This enforces one idle APB cycle between transfers.
- Requester rule: deassert req (or present a new command) on the edge where ack is sampled high. In IDLE, a still-high req is treated as a new request.
- Minimum latency, req high in IDLE at cycle 0:
  - SETUP in cycle 1, ACCESS in cycle 2.
  - ack in cycle 3 with zero wait states; ack in cycle 3+N with N wait states.
- Non-winning req is ignored (no ack) until its own grant; it is never dropped.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1...
- rdataX holds its last value between reads; it is not cleared on writes.
- ack0 and ack1 are never high in the same cycle.
- paddr low two bits are always 0, regardless of addrX[1:0].

Test Plan:
- Write then read, single port: req0 we0=1 addr0=0x000 wdata0=0xDEADBEEF, apb_sram zero-wait.
  - Required: psel high cycles 1-2, penable cycle 2, ack0 in cycle 3, err0=0, SRAM mem[0]=0xDEADBEEF.
  - Then a read of 0x000 returns rdata0=0xDEADBEEF.
- Boundary address: port 1 writes 0xA5A5A5A5 to addr 0xFFC and reads it back.
  - Required: paddr=0xFFC, mem[1023]=0xA5A5A5A5, rdata1=0xA5A5A5A5.
  - addr 0xFFF also drives paddr=0xFFC.
- Simultaneous requests: req0 and req1 both held for 4 transfers with distinct addresses.
  - Required: grant order 0,1,0,1; ack pulses never overlap; each transfer 4 cycles apart.
- Wait states: bench forces pready low for 3 ACCESS cycles on a read of 0x010.
  - Required: ack0 in cycle 6, paddr/penable stable throughout, rdata0 equals mem[4].
- Timeout: TIMEOUT=4, pready held low.
  - Required: ack1 with err1=1 after 4 ACCESS cycles, rdata1 unchanged.
  - The next request completes normally.
- Reset mid-ACCESS: assert rstn during a wait-stated write.
  - Required: psel/penable/ack0 go to 0 immediately (async), FSM returns to IDLE.
  - After release, port 0 wins a tie.
